// File: rtl/pulse_cmd_pkg.sv
// Shared constants and types for the pulse command controller: opcodes,
// reply bytes, FSM states and timing-register index names.
package pulse_cmd_pkg;

  localparam logic [3:0] OP_WRITE = 4'd1;
  localparam logic [3:0] OP_READ  = 4'd2;
  localparam logic [3:0] OP_CTRL  = 4'd3;

  localparam logic [3:0] CTRL_STOP    = 4'd0;
  localparam logic [3:0] CTRL_RUN     = 4'd1;
  localparam logic [3:0] CTRL_COMMIT  = 4'd2;
  localparam logic [3:0] CTRL_CLR_OVR = 4'd3;

  localparam logic [7:0] BYTE_ACK = 8'h06;
  localparam logic [7:0] BYTE_NAK = 8'h15;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_PAYLOAD,
    ST_EXEC,
    ST_REPLY
  } state_e;

  localparam int REG_PERIOD   = 0;
  localparam int REG_DELAY    = 1;
  localparam int REG_WIDTH1   = 2;
  localparam int REG_WIDTH2   = 3;
  localparam int REG_PREBLK   = 4;
  localparam int REG_SYNC_DLY = 5;
  localparam int REG_SYNC_W   = 6;
  localparam int REG_SPARE    = 7;

endpackage

// File: rtl/pulse_cmd_ctrl_if.sv
// UART byte stream between the UART core (master) and the command
// controller (slave): received bytes in, reply bytes out with ready/valid.
interface pulse_cmd_ctrl_if;
  logic [7:0] rx_data;
  logic       rx_valid;
  logic [7:0] tx_data;
  logic       tx_valid;
  logic       tx_ready;

  modport master (output rx_data, rx_valid, tx_ready, input tx_data, tx_valid);
  modport slave  (input rx_data, rx_valid, tx_ready, output tx_data, tx_valid);
endinterface

// File: rtl/pulse_cfg_bank.sv
// Shadow/active timing register bank. Payload bytes shift in MSB first, the
// shadow copy is written on command, and the active copy loads on commit.
module pulse_cfg_bank #(
  parameter int NUM_REGS   = 8,
  parameter int DATA_BYTES = 4,
  parameter int REG_W      = 8 * DATA_BYTES,
  parameter int IW         = (NUM_REGS > 1) ? $clog2(NUM_REGS) : 1
) (
  input  logic                      clk_pll,
  input  logic                      reset_n,
  input  logic                      byte_en,
  input  logic [7:0]                byte_in,
  input  logic                      wr_en,
  input  logic [IW-1:0]             idx,
  output logic [REG_W-1:0]          rd_data,
  input  logic                      commit_req,
  input  logic                      run_en,
  input  logic                      period_end,
  output logic [NUM_REGS*REG_W-1:0] cfg_regs,
  output logic                      cfg_update
);

  logic [REG_W-1:0] shadow_q [NUM_REGS];
  logic [REG_W-1:0] shadow_d [NUM_REGS];
  logic [REG_W-1:0] active_q [NUM_REGS];
  logic [REG_W-1:0] active_d [NUM_REGS];
  logic [REG_W-1:0] shift_q, shift_d;
  logic             pending_q, pending_d;
  logic             copy;

  // While running, the copy waits for a period boundary; stopped, it is immediate.
  assign copy       = pending_q && (!run_en || period_end);
  assign cfg_update = copy;
  assign rd_data    = shadow_q[idx];

  always_comb begin
    shadow_d  = shadow_q;
    active_d  = active_q;
    shift_d   = shift_q;
    pending_d = pending_q;
    if (byte_en) shift_d = {shift_q[REG_W-9:0], byte_in};
    if (copy) active_d = shadow_q;
    if (wr_en) shadow_d[idx] = shift_q;
    if (copy) pending_d = 1'b0;
    else if (commit_req) pending_d = 1'b1;
  end

  always_ff @(posedge clk_pll or negedge reset_n) begin
    if (!reset_n) begin
      shadow_q  <= '{default: '0};
      active_q  <= '{default: '0};
      shift_q   <= '0;
      pending_q <= 1'b0;
    end else begin
      shadow_q  <= shadow_d;
      active_q  <= active_d;
      shift_q   <= shift_d;
      pending_q <= pending_d;
    end
  end

  for (genvar i = 0; i < NUM_REGS; i++) begin : g_out
    assign cfg_regs[i*REG_W +: REG_W] = active_q[i];
  end

endmodule

// File: rtl/pulse_cmd_ctrl.sv
// Byte-command parser and reply serializer in front of the pulse core config bank.
// state   | meaning
// IDLE    | waiting for an opcode byte
// PAYLOAD | collecting WRITE payload bytes, gap timer running
// EXEC    | one cycle: act on the command, load the reply
// REPLY   | shifting reply bytes out over tx handshake
module pulse_cmd_ctrl
  import pulse_cmd_pkg::*;
#(
  parameter int NUM_REGS    = 8,
  parameter int DATA_BYTES  = 4,
  parameter int REG_W       = 8 * DATA_BYTES,
  parameter int TIMEOUT_CYC = 100000
) (
  input  logic                      clk_pll,
  input  logic                      reset_n,
  pulse_cmd_ctrl_if.slave           uart,
  input  logic                      period_end,
  output logic                      run_en,
  output logic [NUM_REGS*REG_W-1:0] cfg_regs,
  output logic                      cfg_update,
  output logic                      rx_overrun
);

  localparam int IW  = (NUM_REGS > 1) ? $clog2(NUM_REGS) : 1;
  localparam int BCW = $clog2(DATA_BYTES + 1);
  localparam int GCW = $clog2(TIMEOUT_CYC + 1);
  localparam logic [BCW-1:0] LAST_BYTE = BCW'(DATA_BYTES - 1);
  localparam logic [BCW-1:0] N_BYTES   = BCW'(DATA_BYTES);
  localparam logic [GCW-1:0] GAP_LOAD  = GCW'(TIMEOUT_CYC - 1);
  localparam logic [4:0]     NREG5     = 5'(NUM_REGS);

  state_e           state_q, state_d;
  logic [3:0]       op_q, op_d, addr_q, addr_d;
  logic [BCW-1:0]   byte_cnt_q, byte_cnt_d, reply_cnt_q, reply_cnt_d;
  logic [GCW-1:0]   gap_cnt_q, gap_cnt_d;
  logic             abort_q, abort_d, run_q, run_d, ovr_q, ovr_d;
  logic             tx_valid_q, tx_valid_d;
  logic [REG_W-1:0] reply_q, reply_d, rd_data;
  logic             byte_en, wr_en, commit_req, addr_ok;

  assign addr_ok       = {1'b0, addr_q} < NREG5;
  assign uart.tx_data  = reply_q[REG_W-1 -: 8];
  assign uart.tx_valid = tx_valid_q;
  assign run_en        = run_q;
  assign rx_overrun    = ovr_q;

  always_comb begin
    state_d     = state_q;
    op_d        = op_q;
    addr_d      = addr_q;
    byte_cnt_d  = byte_cnt_q;
    gap_cnt_d   = gap_cnt_q;
    abort_d     = abort_q;
    run_d       = run_q;
    ovr_d       = ovr_q;
    tx_valid_d  = tx_valid_q;
    reply_d     = reply_q;
    reply_cnt_d = reply_cnt_q;
    byte_en     = 1'b0;
    wr_en       = 1'b0;
    commit_req  = 1'b0;
    case (state_q)
      ST_IDLE: if (uart.rx_valid) begin
        op_d       = uart.rx_data[7:4];
        addr_d     = uart.rx_data[3:0];
        abort_d    = 1'b0;
        byte_cnt_d = '0;
        gap_cnt_d  = GAP_LOAD;
        state_d    = (uart.rx_data[7:4] == OP_WRITE) ? ST_PAYLOAD : ST_EXEC;
      end
      ST_PAYLOAD: begin
        if (uart.rx_valid) begin
          byte_en   = 1'b1;
          gap_cnt_d = GAP_LOAD;
          if (byte_cnt_q == LAST_BYTE) state_d = ST_EXEC;
          else byte_cnt_d = byte_cnt_q + BCW'(1);
        end else if (gap_cnt_q == '0) begin
          abort_d = 1'b1;
          state_d = ST_EXEC;
        end else begin
          gap_cnt_d = gap_cnt_q - GCW'(1);
        end
      end
      ST_EXEC: begin
        reply_d     = {BYTE_NAK, {(REG_W-8){1'b0}}};
        reply_cnt_d = BCW'(1);
        if (!abort_q) begin
          case (op_q)
            OP_WRITE: if (addr_ok) begin
              wr_en   = 1'b1;
              reply_d = {BYTE_ACK, {(REG_W-8){1'b0}}};
            end
            OP_READ: if (addr_ok) begin
              reply_d     = rd_data;
              reply_cnt_d = N_BYTES;
            end
            OP_CTRL: begin
              reply_d = {BYTE_ACK, {(REG_W-8){1'b0}}};
              case (addr_q)
                CTRL_STOP:    run_d = 1'b0;
                CTRL_RUN:     run_d = 1'b1;
                CTRL_COMMIT:  commit_req = 1'b1;
                CTRL_CLR_OVR: ovr_d = 1'b0;
                default:      reply_d = {BYTE_NAK, {(REG_W-8){1'b0}}};
              endcase
            end
            default: ;
          endcase
        end
        tx_valid_d = 1'b1;
        state_d    = ST_REPLY;
      end
      ST_REPLY: if (uart.tx_ready) begin
        if (reply_cnt_q == BCW'(1)) begin
          tx_valid_d = 1'b0;
          state_d    = ST_IDLE;
        end else begin
          reply_d     = {reply_q[REG_W-9:0], 8'h00};
          reply_cnt_d = reply_cnt_q - BCW'(1);
        end
      end
      default: state_d = ST_IDLE;
    endcase
    // A byte arriving while busy is dropped; the flag wins over a same-cycle clear.
    if (uart.rx_valid && (state_q == ST_EXEC || state_q == ST_REPLY)) ovr_d = 1'b1;
  end

  always_ff @(posedge clk_pll or negedge reset_n) begin
    if (!reset_n) begin
      state_q     <= ST_IDLE;
      op_q        <= '0;
      addr_q      <= '0;
      byte_cnt_q  <= '0;
      gap_cnt_q   <= '0;
      abort_q     <= 1'b0;
      run_q       <= 1'b0;
      ovr_q       <= 1'b0;
      tx_valid_q  <= 1'b0;
      reply_q     <= '0;
      reply_cnt_q <= '0;
    end else begin
      state_q     <= state_d;
      op_q        <= op_d;
      addr_q      <= addr_d;
      byte_cnt_q  <= byte_cnt_d;
      gap_cnt_q   <= gap_cnt_d;
      abort_q     <= abort_d;
      run_q       <= run_d;
      ovr_q       <= ovr_d;
      tx_valid_q  <= tx_valid_d;
      reply_q     <= reply_d;
      reply_cnt_q <= reply_cnt_d;
    end
  end

  pulse_cfg_bank #(
    .NUM_REGS  (NUM_REGS),
    .DATA_BYTES(DATA_BYTES),
    .REG_W     (REG_W),
    .IW        (IW)
  ) u_bank (
    .clk_pll   (clk_pll),
    .reset_n   (reset_n),
    .byte_en   (byte_en),
    .byte_in   (uart.rx_data),
    .wr_en     (wr_en),
    .idx       (addr_q[IW-1:0]),
    .rd_data   (rd_data),
    .commit_req(commit_req),
    .run_en    (run_q),
    .period_end(period_end),
    .cfg_regs  (cfg_regs),
    .cfg_update(cfg_update)
  );

endmodule

// File: tb/tb_pulse_cmd_ctrl.sv
// Directed bench for pulse_cmd_ctrl: expected reply bytes go into a queue,
// a monitor pops and compares each accepted tx byte.
module tb_pulse_cmd_ctrl;
  import pulse_cmd_pkg::*;

  localparam int NR = 8;
  localparam int DB = 4;
  localparam int RW = 32;
  localparam int TO = 300;

  logic             clk_pll = 1'b0;
  logic             reset_n = 1'b0;
  logic             period_end = 1'b0;
  logic             run_en, cfg_update, rx_overrun;
  logic [NR*RW-1:0] cfg_regs;

  pulse_cmd_ctrl_if u_if ();

  pulse_cmd_ctrl #(
    .NUM_REGS(NR), .DATA_BYTES(DB), .REG_W(RW), .TIMEOUT_CYC(TO)
  ) dut (
    .clk_pll   (clk_pll),
    .reset_n   (reset_n),
    .uart      (u_if),
    .period_end(period_end),
    .run_en    (run_en),
    .cfg_regs  (cfg_regs),
    .cfg_update(cfg_update),
    .rx_overrun(rx_overrun)
  );

  always #5 clk_pll = ~clk_pll;

  int         total = 0;
  int         bad = 0;
  logic [7:0] exp_q[$];
  logic [7:0] exp_b;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  always @(negedge clk_pll) begin
    if (reset_n && u_if.tx_valid && u_if.tx_ready) begin
      if (exp_q.size() == 0) begin
        total++;
        bad++;
        $display("FAIL tx_extra: got %0h expected no byte", u_if.tx_data);
      end else begin
        exp_b = exp_q.pop_front();
        chk("tx_byte", u_if.tx_data, exp_b);
      end
    end
  end

  function automatic logic [31:0] creg(input int i);
    return cfg_regs[i*RW +: RW];
  endfunction

  task automatic tick();
    @(posedge clk_pll);
    #1;
  endtask

  task automatic send_byte(input logic [7:0] b);
    u_if.rx_data  = b;
    u_if.rx_valid = 1'b1;
    tick();
    u_if.rx_valid = 1'b0;
  endtask

  task automatic wait_done(input string name, input int maxc);
    int n = 0;
    while ((exp_q.size() != 0 || u_if.tx_valid) && n < maxc) begin
      tick();
      n++;
    end
    if (exp_q.size() != 0 || u_if.tx_valid) begin
      total++;
      bad++;
      $display("FAIL %s_timeout: got %0d bytes outstanding expected 0", name, exp_q.size());
      exp_q.delete();
    end
  endtask

  task automatic do_cmd(input logic [7:0] opb, input logic [7:0] rep);
    exp_q.push_back(rep);
    send_byte(opb);
    wait_done("cmd", 20);
  endtask

  task automatic do_write(input logic [7:0] opb, input logic [31:0] d, input logic [7:0] rep);
    exp_q.push_back(rep);
    send_byte(opb);
    for (int i = 0; i < DB; i++) send_byte(d[31-8*i -: 8]);
    wait_done("write", 20);
  endtask

  task automatic do_read(input logic [7:0] opb, input logic [31:0] d, input bit ok);
    if (ok) for (int i = 0; i < DB; i++) exp_q.push_back(d[31-8*i -: 8]);
    else exp_q.push_back(BYTE_NAK);
    send_byte(opb);
    wait_done("read", 40);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: got no finish expected finish before 500us");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [7:0] d0;
    bit         stable;
    u_if.rx_data  = 8'h00;
    u_if.rx_valid = 1'b0;
    u_if.tx_ready = 1'b1;
    repeat (3) tick();
    chk("rst_tx_valid", u_if.tx_valid, 0);
    chk("rst_tx_data", u_if.tx_data, 0);
    chk("rst_run_en", run_en, 0);
    chk("rst_cfg_update", cfg_update, 0);
    chk("rst_overrun", rx_overrun, 0);
    chk("rst_cfg_zero", cfg_regs == '0, 1);
    reset_n = 1'b1;
    tick();

    // write reg1, check reply latency, shadow only
    exp_q.push_back(BYTE_ACK);
    send_byte(8'h11);
    send_byte(8'hDE); send_byte(8'hAD); send_byte(8'hBE); send_byte(8'hEF);
    chk("lat_exec_no_valid", u_if.tx_valid, 0);
    tick();
    chk("lat_reply_valid", u_if.tx_valid, 1);
    wait_done("write1", 20);
    chk("cfg1_before_commit", creg(1), 32'h0);
    do_read(8'h21, 32'hDEADBEEF, 1);

    // running commit applies at a later period_end
    do_cmd(8'h31, BYTE_ACK);
    chk("run_en_set", run_en, 1);
    do_cmd(8'h32, BYTE_ACK);
    repeat (50) tick();
    chk("cfg1_pending", creg(1), 32'h0);
    chk("no_update_pending", cfg_update, 0);
    period_end = 1'b1;
    #1;
    chk("update_on_pe", cfg_update, 1);
    tick();
    period_end = 1'b0;
    #1;
    chk("cfg1_committed", creg(1), 32'hDEADBEEF);
    chk("update_one_cycle", cfg_update, 0);

    // commit in the same cycle as period_end waits for the next one
    do_write(8'h13, 32'h12345678, BYTE_ACK);
    exp_q.push_back(BYTE_ACK);
    send_byte(8'h32);
    period_end = 1'b1;
    #1;
    chk("same_cycle_pe_no_update", cfg_update, 0);
    tick();
    period_end = 1'b0;
    wait_done("commit2", 20);
    chk("cfg3_still_old", creg(3), 32'h0);
    period_end = 1'b1;
    #1;
    chk("update_next_pe", cfg_update, 1);
    tick();
    period_end = 1'b0;
    #1;
    chk("cfg3_committed", creg(3), 32'h12345678);

    // bad frames
    do_cmd(8'h55, BYTE_NAK);
    do_write(8'h19, 32'hCAFEBABE, BYTE_NAK);
    do_read(8'h21, 32'hDEADBEEF, 1);
    do_cmd(8'h34, BYTE_NAK);
    do_read(8'h29, 32'h0, 0);

    // payload timeout
    exp_q.push_back(BYTE_NAK);
    send_byte(8'h12);
    send_byte(8'h01);
    repeat (TO - 10) tick();
    chk("timeout_not_early", u_if.tx_valid, 0);
    wait_done("timeout", 40);
    do_read(8'h22, 32'h0, 1);
    do_write(8'h12, 32'h0A0B0C0D, BYTE_ACK);
    do_read(8'h22, 32'h0A0B0C0D, 1);

    // backpressure and overrun
    u_if.tx_ready = 1'b0;
    for (int i = 0; i < DB; i++) exp_q.push_back(8'hDE + 8'h0 * 8'(i));
    exp_q.delete();
    exp_q.push_back(8'hDE); exp_q.push_back(8'hAD);
    exp_q.push_back(8'hBE); exp_q.push_back(8'hEF);
    send_byte(8'h21);
    for (int k = 0; k < DB; k++) begin
      for (int n = 0; n < 10 && !u_if.tx_valid; n++) tick();
      d0 = u_if.tx_data;
      stable = 1'b1;
      for (int c = 0; c < 20; c++) begin
        if (k == 0 && c == 5) send_byte(8'h77);
        else tick();
        if (u_if.tx_data !== d0 || !u_if.tx_valid) stable = 1'b0;
      end
      chk("bp_stable", stable, 1);
      u_if.tx_ready = 1'b1;
      tick();
      u_if.tx_ready = 1'b0;
    end
    u_if.tx_ready = 1'b1;
    tick();
    chk("bp_reply_done", u_if.tx_valid, 0);
    chk("overrun_set", rx_overrun, 1);
    do_cmd(8'h33, BYTE_ACK);
    chk("overrun_cleared", rx_overrun, 0);

    // reset mid-payload
    send_byte(8'h11);
    send_byte(8'hAA);
    reset_n = 1'b0;
    tick();
    chk("rstp_tx_valid", u_if.tx_valid, 0);
    chk("rstp_run_en", run_en, 0);
    chk("rstp_cfg_zero", cfg_regs == '0, 1);
    chk("rstp_overrun", rx_overrun, 0);
    chk("rstp_update", cfg_update, 0);
    reset_n = 1'b1;
    tick();
    do_read(8'h21, 32'h0, 1);

    // reset mid-reply
    do_write(8'h11, 32'hCAFEF00D, BYTE_ACK);
    u_if.tx_ready = 1'b0;
    send_byte(8'h21);
    tick();
    tick();
    chk("rstr_reply_active", u_if.tx_valid, 1);
    reset_n = 1'b0;
    exp_q.delete();
    #1;
    chk("rstr_tx_valid", u_if.tx_valid, 0);
    chk("rstr_tx_data", u_if.tx_data, 0);
    tick();
    reset_n = 1'b1;
    u_if.tx_ready = 1'b1;
    tick();
    do_write(8'h15, 32'h55AA33CC, BYTE_ACK);
    do_read(8'h25, 32'h55AA33CC, 1);
    do_read(8'h21, 32'h0, 1);

    repeat (5) tick();
    chk("queue_drained", exp_q.size(), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
